// File: rtl/region_guard_pkg.sv
// Shared constants and helpers for the region_guard write/exec boundary monitor.
package region_guard_pkg;

  // Monitor state: RUN lets the core execute, KILL holds it in reset.
  typedef enum logic {
    RG_RUN  = 1'b0,
    RG_KILL = 1'b1
  } rg_state_e;

  // Bit positions inside a region's 3-bit mode field.
  localparam int RG_M_CPU  = 0;  // CPU writes are forbidden
  localparam int RG_M_DMA  = 1;  // DMA writes are forbidden
  localparam int RG_M_TCBX = 2;  // CPU writes allowed while pc is inside the TCB

  // Bit positions inside the sticky cause vector {exec, dma, cpu}.
  localparam int RG_C_CPU  = 0;
  localparam int RG_C_DMA  = 1;
  localparam int RG_C_EXEC = 2;

  // Region code reported when the capture is an execution violation.
  localparam logic [2:0] RG_EXEC_REGION = 3'h7;

  // Inclusive unsigned range test; addresses are zero-extended to 32 bits
  // by the caller, so any ADDR_W up to 32 works. lo > hi never matches.
  function automatic logic rg_in_range(input logic [31:0] a,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    rg_in_range = (a >= lo) && (a <= hi);
  endfunction

  // Eight-bit counter increment that sticks at all-ones.
  function automatic logic [7:0] rg_sat_inc8(input logic [7:0] v);
    rg_sat_inc8 = (v == 8'hFF) ? 8'hFF : (v + 8'h01);
  endfunction

endpackage

// File: rtl/region_guard_if.sv
// Bus bundle between the openMSP430 core side and the region_guard monitor.
// master: core/system side driving the observed signals; slave: the monitor.
interface region_guard_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] data_addr;
  logic              data_en;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_en;
  logic [ADDR_W-1:0] ER_min;
  logic [ADDR_W-1:0] ER_max;
  logic              er_check_en;
  logic              kill_rst;
  logic [7:0]        viol_cnt;
  logic [2:0]        viol_src;
  logic [2:0]        viol_region;
  logic [ADDR_W-1:0] viol_addr;

  modport master (
    output pc, data_addr, data_en, dma_addr, dma_en, ER_min, ER_max, er_check_en,
    input  kill_rst, viol_cnt, viol_src, viol_region, viol_addr
  );

  modport slave (
    input  pc, data_addr, data_en, dma_addr, dma_en, ER_min, ER_max, er_check_en,
    output kill_rst, viol_cnt, viol_src, viol_region, viol_addr
  );
endinterface

// File: rtl/region_guard_match.sv
// region_match: bounds comparator for one protected region. Produces the
// per-region CPU and DMA write-violation hits; the TCB exemption applies to
// CPU writes only.
module region_match
  import region_guard_pkg::*;
#(
  parameter int              ADDR_W = 16,
  parameter logic [ADDR_W-1:0] MIN  = '0,
  parameter logic [ADDR_W-1:0] MAX  = '0,
  parameter logic [2:0]      MODE   = 3'b011
) (
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              data_en,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_en,
  input  logic              in_tcb,
  output logic              cpu_hit,
  output logic              dma_hit
);
  logic cpu_in_s;
  logic dma_in_s;

  assign cpu_in_s = rg_in_range(32'(data_addr), 32'(MIN), 32'(MAX));
  assign dma_in_s = rg_in_range(32'(dma_addr), 32'(MIN), 32'(MAX));

  assign cpu_hit = data_en && cpu_in_s && MODE[RG_M_CPU] && !(MODE[RG_M_TCBX] && in_tcb);
  assign dma_hit = dma_en && dma_in_s && MODE[RG_M_DMA];
endmodule

// File: rtl/region_guard.sv
// region_guard: multi-region write/execution boundary monitor for the CFA
// subsystem. Drives a registered kill reset on any violation and holds it
// for at least KILL_HOLD cycles and until the core sits at RESET_HANDLER.
// Optional build macro: VIOL_LOG_EN enables the viol_region/viol_addr capture.
module region_guard
  import region_guard_pkg::*;
#(
  parameter int                          NUM_REGIONS     = 4,
  parameter int                          ADDR_W          = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MIN_VEC  = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MAX_VEC  = '0,
  parameter logic [NUM_REGIONS*3-1:0]    REGION_MODE_VEC = {NUM_REGIONS{3'b011}},
  parameter logic [ADDR_W-1:0]           TCB_BASE        = 16'hA000,
  parameter logic [ADDR_W-1:0]           TCB_SIZE        = 16'h4000,
  parameter logic [ADDR_W-1:0]           RESET_HANDLER   = 16'h0000,
  parameter int                          KILL_HOLD       = 8
) (
  input logic           clk,
  input logic           reset,
  region_guard_if.slave bus
);
  localparam int HOLD_W = $clog2(KILL_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(KILL_HOLD - 1);
  // One extra bit so TCB_BASE+TCB_SIZE at the top of memory does not wrap.
  localparam logic [ADDR_W:0] TCB_END = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE};

  logic [NUM_REGIONS-1:0] cpu_hit_s;
  logic [NUM_REGIONS-1:0] dma_hit_s;
  logic                   in_tcb_s;
  logic                   cpu_v_s;
  logic                   dma_v_s;
  logic                   exec_v_s;
  logic                   viol_s;
  logic [2:0]             cause_s;

  rg_state_e              state_r;
  logic                   kill_rst_r;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [7:0]             viol_cnt_r;
  logic [2:0]             viol_src_r;

  assign in_tcb_s = (bus.pc >= TCB_BASE) && ({1'b0, bus.pc} < TCB_END);

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    region_match #(
      .ADDR_W (ADDR_W),
      .MIN    (REGION_MIN_VEC[i*ADDR_W +: ADDR_W]),
      .MAX    (REGION_MAX_VEC[i*ADDR_W +: ADDR_W]),
      .MODE   (REGION_MODE_VEC[i*3 +: 3])
    ) u_match (
      .data_addr (bus.data_addr),
      .data_en   (bus.data_en),
      .dma_addr  (bus.dma_addr),
      .dma_en    (bus.dma_en),
      .in_tcb    (in_tcb_s),
      .cpu_hit   (cpu_hit_s[i]),
      .dma_hit   (dma_hit_s[i])
    );
  end

  assign cpu_v_s  = |cpu_hit_s;
  assign dma_v_s  = |dma_hit_s;
  // The reset handler itself is always executable so a killed core can restart.
  assign exec_v_s = bus.er_check_en && ((bus.pc < bus.ER_min) || (bus.pc > bus.ER_max)) &&
                    !in_tcb_s && (bus.pc != RESET_HANDLER);
  assign viol_s   = cpu_v_s || dma_v_s || exec_v_s;

  // Pack the per-class violations into the cause-vector layout.
  always_comb begin
    cause_s            = 3'b000;
    cause_s[RG_C_CPU]  = cpu_v_s;
    cause_s[RG_C_DMA]  = dma_v_s;
    cause_s[RG_C_EXEC] = exec_v_s;
  end

  // RUN/KILL state machine with hold counter, violation counter and sticky cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= RG_KILL;
      kill_rst_r <= 1'b1;
      hold_cnt_r <= '0;
      viol_cnt_r <= 8'h00;
      viol_src_r <= 3'b000;
    end else begin
      case (state_r)
        RG_RUN: begin
          if (viol_s) begin
            state_r    <= RG_KILL;
            kill_rst_r <= 1'b1;
            hold_cnt_r <= HOLD_RELOAD;
            viol_cnt_r <= rg_sat_inc8(viol_cnt_r);
            viol_src_r <= viol_src_r | cause_s;
          end else begin
            kill_rst_r <= 1'b0;
          end
        end
        RG_KILL: begin
          if (viol_s) begin
            // Repeat offence: restart the hold window, count only RUN->KILL.
            kill_rst_r <= 1'b1;
            hold_cnt_r <= HOLD_RELOAD;
            viol_src_r <= viol_src_r | cause_s;
          end else if ((hold_cnt_r == '0) && (bus.pc == RESET_HANDLER)) begin
            state_r    <= RG_RUN;
            kill_rst_r <= 1'b0;
          end else if (hold_cnt_r != '0) begin
            kill_rst_r <= 1'b1;
            hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
          end else begin
            kill_rst_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= RG_KILL;
          kill_rst_r <= 1'b1;
          hold_cnt_r <= HOLD_RELOAD;
        end
      endcase
    end
  end

  assign bus.kill_rst = kill_rst_r;
  assign bus.viol_cnt = viol_cnt_r;
  assign bus.viol_src = viol_src_r;

`ifdef VIOL_LOG_EN
  logic [2:0]        cpu_idx_s;
  logic [2:0]        dma_idx_s;
  logic [2:0]        log_region_s;
  logic [ADDR_W-1:0] log_addr_s;
  logic [2:0]        viol_region_r;
  logic [ADDR_W-1:0] viol_addr_r;

  // Lowest-index hitting region for each write source (scan high to low).
  always_comb begin
    cpu_idx_s = 3'h0;
    dma_idx_s = 3'h0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (cpu_hit_s[i]) begin
        cpu_idx_s = 3'(i);
      end else begin
        cpu_idx_s = cpu_idx_s;
      end
      if (dma_hit_s[i]) begin
        dma_idx_s = 3'(i);
      end else begin
        dma_idx_s = dma_idx_s;
      end
    end
  end

  // Capture priority: CPU, then DMA, then execution.
  always_comb begin
    log_region_s = RG_EXEC_REGION;
    log_addr_s   = bus.pc;
    if (cpu_v_s) begin
      log_region_s = cpu_idx_s;
      log_addr_s   = bus.data_addr;
    end else if (dma_v_s) begin
      log_region_s = dma_idx_s;
      log_addr_s   = bus.dma_addr;
    end else begin
      log_region_s = RG_EXEC_REGION;
      log_addr_s   = bus.pc;
    end
  end

  // Record the latest offending region/address on every violating cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_region_r <= 3'h0;
      viol_addr_r   <= '0;
    end else if (viol_s) begin
      viol_region_r <= log_region_s;
      viol_addr_r   <= log_addr_s;
    end else begin
      viol_region_r <= viol_region_r;
      viol_addr_r   <= viol_addr_r;
    end
  end

  assign bus.viol_region = viol_region_r;
  assign bus.viol_addr   = viol_addr_r;
`else
  assign bus.viol_region = 3'h0;
  assign bus.viol_addr   = '0;
`endif

endmodule

// File: tb/tb_region_guard.sv
// Directed bench for region_guard: a reference model pushes expected outputs
// into a scoreboard queue as each input vector is applied; the entry is popped
// and compared one clock later. Spot checks against fixed values follow the
// key scenarios.
module tb_region_guard;
  localparam int NR        = 4;
  localparam int AW        = 16;
  localparam int KILL_HOLD = 8;
  localparam logic [AW-1:0] RH = 16'h0000;
`ifdef VIOL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  // Region table: 0 TCB-exempt full protect, 1 CPU+DMA, 2 DMA only (overlaps 1),
  // 3 inverted bounds (never matches).
  localparam logic [15:0] R_MIN  [NR] = '{16'h0180, 16'h1000, 16'h1080, 16'h3000};
  localparam logic [15:0] R_MAX  [NR] = '{16'h0221, 16'h10FF, 16'h11FF, 16'h2000};
  localparam logic [2:0]  R_MODE [NR] = '{3'b111, 3'b011, 3'b010, 3'b001};

  typedef struct {
    logic        kill;
    logic [7:0]  cnt;
    logic [2:0]  src;
    logic [2:0]  rgn;
    logic [15:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  logic        m_kill;
  int          m_hold;
  logic [7:0]  m_cnt;
  logic [2:0]  m_src;
  logic [2:0]  m_rgn;
  logic [15:0] m_addr;

  region_guard_if #(.ADDR_W(AW)) bus ();

  region_guard #(
    .NUM_REGIONS     (NR),
    .ADDR_W          (AW),
    .REGION_MIN_VEC  ({16'h3000, 16'h1080, 16'h1000, 16'h0180}),
    .REGION_MAX_VEC  ({16'h2000, 16'h11FF, 16'h10FF, 16'h0221}),
    .REGION_MODE_VEC ({3'b001, 3'b010, 3'b011, 3'b111}),
    .TCB_BASE        (16'hA000),
    .TCB_SIZE        (16'h4000),
    .RESET_HANDLER   (RH),
    .KILL_HOLD       (KILL_HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_kill = 1'b1; m_hold = 0; m_cnt = 8'h00; m_src = 3'b000; m_rgn = 3'h0; m_addr = 16'h0000;
  endtask

  // Expected next outputs for the inputs currently on the bus.
  task automatic model_push();
    logic tcb, cv, dv, ev;
    int   ci, di;
    exp_t e;
    tcb = (bus.pc >= 16'hA000) && (bus.pc <= 16'hDFFF);
    ci = -1;
    di = -1;
    for (int i = NR - 1; i >= 0; i--) begin
      if (bus.data_en && bus.data_addr >= R_MIN[i] && bus.data_addr <= R_MAX[i] &&
          R_MODE[i][0] && !(R_MODE[i][2] && tcb)) ci = i;
      if (bus.dma_en && bus.dma_addr >= R_MIN[i] && bus.dma_addr <= R_MAX[i] &&
          R_MODE[i][1]) di = i;
    end
    cv = (ci >= 0);
    dv = (di >= 0);
    ev = bus.er_check_en && (bus.pc < bus.ER_min || bus.pc > bus.ER_max) && !tcb && bus.pc != RH;
    if (cv || dv || ev) begin
      if (!m_kill) begin
        m_kill = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
      end
      m_hold = KILL_HOLD - 1;
      m_src  = m_src | {ev, dv, cv};
      if (LOG) begin
        if (cv) begin m_rgn = 3'(ci); m_addr = bus.data_addr; end
        else if (dv) begin m_rgn = 3'(di); m_addr = bus.dma_addr; end
        else begin m_rgn = 3'h7; m_addr = bus.pc; end
      end
    end else if (m_kill) begin
      if (m_hold == 0 && bus.pc == RH) m_kill = 1'b0;
      else if (m_hold != 0) m_hold = m_hold - 1;
    end
    e.kill = m_kill; e.cnt = m_cnt; e.src = m_src; e.rgn = m_rgn; e.addr = m_addr;
    exp_q.push_back(e);
  endtask

  // Apply current inputs for one clock and compare against the scoreboard.
  task automatic tick(input string tag);
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".kill"}, 32'(bus.kill_rst), 32'(e.kill));
    chk({tag, ".cnt"},  32'(bus.viol_cnt), 32'(e.cnt));
    chk({tag, ".src"},  32'(bus.viol_src), 32'(e.src));
    chk({tag, ".rgn"},  32'(bus.viol_region), 32'(e.rgn));
    chk({tag, ".addr"}, 32'(bus.viol_addr), 32'(e.addr));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc = 16'h0100; bus.data_addr = 16'h0000; bus.data_en = 1'b0;
    bus.dma_addr = 16'h0000; bus.dma_en = 1'b0;
    bus.ER_min = 16'hE000; bus.ER_max = 16'hE0FF; bus.er_check_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.kill", 32'(bus.kill_rst), 32'd1);
    chk("rst.cnt",  32'(bus.viol_cnt), 32'd0);
    chk("rst.src",  32'(bus.viol_src), 32'd0);
    chk("rst.rgn",  32'(bus.viol_region), 32'd0);
    chk("rst.addr", 32'(bus.viol_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Power-on release needs pc at the reset handler.
    tick("t1_pc_busy");
    chk("t1_still_kill", 32'(bus.kill_rst), 32'd1);
    bus.pc = 16'h0000;
    tick("t1_release");
    chk("t1_run", 32'(bus.kill_rst), 32'd0);

    // CPU write into region 0 from outside the TCB.
    bus.pc = 16'hE000; bus.data_addr = 16'h0200; bus.data_en = 1'b1;
    tick("t2_cpu");
    chk("t2_kill", 32'(bus.kill_rst), 32'd1);
    chk("t2_cnt",  32'(bus.viol_cnt), 32'd1);
    chk("t2_src",  32'(bus.viol_src), 32'd1);
    chk("t2_rgn",  32'(bus.viol_region), 32'd0);
    chk("t2_addr", 32'(bus.viol_addr), LOG ? 32'h0200 : 32'h0);

    // Minimum hold: kill stays for exactly KILL_HOLD cycles with pc at handler.
    bus.data_en = 1'b0; bus.pc = 16'h0000;
    for (int k = 0; k < KILL_HOLD - 1; k++) begin
      tick("t4_hold");
      chk("t4_not_early", 32'(bus.kill_rst), 32'd1);
    end
    tick("t4_release");
    chk("t4_released", 32'(bus.kill_rst), 32'd0);

    // TCB exemption for CPU, none for DMA.
    pulse_reset();
    tick("t3_boot");
    bus.pc = 16'hA100; bus.data_addr = 16'h0190; bus.data_en = 1'b1;
    tick("t3_tcbx");
    chk("t3_no_kill", 32'(bus.kill_rst), 32'd0);
    bus.dma_addr = 16'h0190; bus.dma_en = 1'b1;
    tick("t3_dma");
    chk("t3_kill", 32'(bus.kill_rst), 32'd1);
    chk("t3_src",  32'(bus.viol_src), 32'd2);
    chk("t3_addr", 32'(bus.viol_addr), LOG ? 32'h0190 : 32'h0);

    // Asynchronous reset in the middle of KILL.
    bus.data_en = 1'b0; bus.dma_en = 1'b0; bus.pc = 16'h0000;
    tick("t3_hold");
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst.kill", 32'(bus.kill_rst), 32'd1);
    chk("mid_rst.cnt",  32'(bus.viol_cnt), 32'd0);
    chk("mid_rst.src",  32'(bus.viol_src), 32'd0);
    chk("mid_rst.addr", 32'(bus.viol_addr), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick("mid_rst_release");
    chk("mid_rst_run", 32'(bus.kill_rst), 32'd0);

    // CPU and DMA together in overlapping regions 1 and 2.
    bus.pc = 16'hE000; bus.data_addr = 16'h1090; bus.data_en = 1'b1;
    bus.dma_addr = 16'h1090; bus.dma_en = 1'b1;
    tick("t5_both");
    chk("t5_src",  32'(bus.viol_src), 32'd3);
    chk("t5_rgn",  32'(bus.viol_region), LOG ? 32'd1 : 32'd0);
    chk("t5_addr", 32'(bus.viol_addr), LOG ? 32'h1090 : 32'h0);
    bus.data_en = 1'b0; bus.dma_addr = 16'h1150;
    tick("t5_in_kill");
    chk("t5_cnt_same", 32'(bus.viol_cnt), 32'd1);
    // CPU writes into DMA-only and inverted regions are harmless.
    bus.dma_en = 1'b0; bus.data_en = 1'b1; bus.data_addr = 16'h1150; bus.pc = 16'h0000;
    for (int k = 0; k < KILL_HOLD - 1; k++) tick("t5_hold");
    chk("t5_reload_kill", 32'(bus.kill_rst), 32'd1);
    bus.data_addr = 16'h2800;
    tick("t5_release");
    chk("t5_run", 32'(bus.kill_rst), 32'd0);
    bus.data_addr = 16'h0200; bus.pc = 16'hDFFF;
    tick("tcb_top_exempt");

    // ER boundaries and the TCB are executable.
    bus.data_en = 1'b0; bus.er_check_en = 1'b1;
    bus.pc = 16'hE000; tick("er_min_edge");
    bus.pc = 16'hE0FF; tick("er_max_edge");
    bus.pc = 16'hDFFF; tick("er_in_tcb");
    chk("er_no_kill", 32'(bus.kill_rst), 32'd0);

    // Execution violation and counter saturation.
    pulse_reset();
    bus.pc = 16'h0000;
    tick("t6_boot");
    bus.pc = 16'hE200;
    tick("t6_exec");
    chk("t6_kill", 32'(bus.kill_rst), 32'd1);
    chk("t6_src",  32'(bus.viol_src), 32'd4);
    chk("t6_rgn",  32'(bus.viol_region), LOG ? 32'd7 : 32'd0);
    chk("t6_addr", 32'(bus.viol_addr), LOG ? 32'hE200 : 32'h0);
    for (int k = 0; k < 256; k++) begin
      bus.pc = 16'h0000;
      repeat (KILL_HOLD) tick("t6_wait");
      bus.pc = 16'hE200;
      tick("t6_again");
    end
    chk("t6_sat", 32'(bus.viol_cnt), 32'hFF);
    chk("t6_src_sticky", 32'(bus.viol_src), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
